fir_tap_scheduler: RTL and testbench

- Sequencing controller for the folded 29-tap complex FIR datapath.
- Gates sample intake on coefficient readiness and pulls samples from the input sample FIFO.
- Time-multiplexes the complex multiplier bank over NUM_GROUPS tap groups through the datapath mux select.
- Tracks the multiplier pipeline latency so that it can drive the partial-product accumulate, final-rounding and output-push strobes.

---
 rtl/fir_tap_scheduler_if.sv | 25 ++
 rtl/fir_tap_scheduler.sv | 145 ++++++++++++++
 tb/tb_fir_tap_scheduler.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_tap_scheduler_if.sv
// Control/status bundle between the FIR tap scheduler and the surrounding datapath.
// The slave modport is the scheduler's view; master is the datapath/FIFO side.
interface fir_tap_scheduler_if;
  logic       PushCoef;
  logic [4:0] CoefAddr;
  logic       fifo_empty;
  logic       fifo_pull;
  logic [1:0] mux_sel;
  logic       acc_clear;
  logic       acc_valid;
  logic       round_en;
  logic       push_out;
  logic       coef_ready;
  logic       busy;

  modport slave (
    input  PushCoef, CoefAddr, fifo_empty,
    output fifo_pull, mux_sel, acc_clear, acc_valid, round_en, push_out, coef_ready, busy
  );

  modport master (
    output PushCoef, CoefAddr, fifo_empty,
    input  fifo_pull, mux_sel, acc_clear, acc_valid, round_en, push_out, coef_ready, busy
  );
endinterface

// File: rtl/fir_tap_scheduler.sv
// Sequencing controller for the folded complex FIR: gates intake on coefficient
// readiness, steps tap groups through the multiplier bank and times accumulate/round/push.
module fir_tap_scheduler #(
  parameter int unsigned NUM_GROUPS = 3,
  parameter int unsigned MULT_LAT   = 2,
  parameter int unsigned NUM_COEF   = 15
) (
  input logic               clk,
  input logic               Reset,
  fir_tap_scheduler_if.slave bus
);

  localparam int unsigned GRP_W  = 2;
  localparam int unsigned ADDR_W = 5;
  localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NUM_GROUPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULL  = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [GRP_W-1:0]     grp;
  logic [GRP_W-1:0]     grp_next;
  logic                 pull_c;
  logic                 issue_c;
  logic                 start_ok_c;

  logic [NUM_COEF-1:0]  bitmap;
  logic [NUM_COEF-1:0]  wr_mask;
  logic [NUM_COEF-1:0]  bitmap_next;
  logic                 coef_ready;

  logic [MULT_LAT-1:0]  tag_v;
  logic [MULT_LAT-1:0]  tag_first;
  logic [MULT_LAT-1:0]  tag_last;
  logic                 round_en;
  logic                 push_out;

  // Decode a coefficient write into a one-hot mask; out-of-range addresses yield no bit.
  always_comb begin
    wr_mask = '0;
    if (bus.PushCoef) begin
      for (int unsigned i = 0; i < NUM_COEF; i++) begin
        if (bus.CoefAddr == ADDR_W'(i)) begin
          wr_mask[i] = 1'b1;
        end
      end
    end
  end

  assign bitmap_next = bitmap | wr_mask;

  // Sticky coefficient bitmap; ready follows the write that completes it by one cycle.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bitmap     <= '0;
      coef_ready <= 1'b0;
    end else begin
      bitmap     <= bitmap_next;
      coef_ready <= &bitmap_next;
    end
  end

  assign start_ok_c = coef_ready & ~bus.fifo_empty & ~bus.PushCoef;

  // State register.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      grp   <= '0;
    end else begin
      state <= state_next;
      grp   <= grp_next;
    end
  end

  // Next-state logic. A coefficient write or an empty FIFO in the pull cycle holds the
  // pull off for that cycle, so a pop never coincides with fifo_empty or PushCoef.
  always_comb begin
    state_next = state;
    grp_next   = grp;
    pull_c     = 1'b0;
    issue_c    = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok_c) begin
          state_next = PULL;
        end
      end
      PULL: begin
        if (!bus.fifo_empty && !bus.PushCoef) begin
          pull_c     = 1'b1;
          grp_next   = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue_c = 1'b1;
        if (grp == LAST_GRP) begin
          state_next = start_ok_c ? PULL : IDLE;
        end else begin
          grp_next = grp + GRP_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Issue tags ride a MULT_LAT-deep shift register to line up with multiplier outputs.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      tag_v     <= '0;
      tag_first <= '0;
      tag_last  <= '0;
      round_en  <= 1'b0;
      push_out  <= 1'b0;
    end else begin
      tag_v[0]     <= issue_c;
      tag_first[0] <= issue_c & (grp == '0);
      tag_last[0]  <= issue_c & (grp == LAST_GRP);
      for (int unsigned i = 1; i < MULT_LAT; i++) begin
        tag_v[i]     <= tag_v[i-1];
        tag_first[i] <= tag_first[i-1];
        tag_last[i]  <= tag_last[i-1];
      end
      round_en <= tag_v[MULT_LAT-1] & tag_last[MULT_LAT-1];
      push_out <= round_en;
    end
  end

  assign bus.fifo_pull  = pull_c;
  assign bus.mux_sel    = grp;
  assign bus.acc_valid  = tag_v[MULT_LAT-1];
  assign bus.acc_clear  = tag_v[MULT_LAT-1] & tag_first[MULT_LAT-1];
  assign bus.round_en   = round_en;
  assign bus.push_out   = push_out;
  assign bus.coef_ready = coef_ready;
  assign bus.busy       = (state != IDLE) | (|tag_v) | round_en | push_out;

endmodule

// File: tb/tb_fir_tap_scheduler.sv
// Directed bench for fir_tap_scheduler: coefficient gating, single/streaming samples,
// FIFO starvation, coefficient writes mid-stream and reset while samples are in flight.
module tb_fir_tap_scheduler;

  logic clk;
  logic Reset;
  int   checks;
  int   errors;

  fir_tap_scheduler_if bus ();

  fir_tap_scheduler dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock cycle: inputs change just after the rising edge, outputs are read at the falling edge.
  task automatic cyc(input logic p, input logic [4:0] a, input logic e);
    @(posedge clk);
    #1;
    bus.PushCoef   = p;
    bus.CoefAddr   = a;
    bus.fifo_empty = e;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    Reset          = 1'b1;
    bus.PushCoef   = 1'b0;
    bus.CoefAddr   = 5'd0;
    bus.fifo_empty = 1'b1;
    repeat (3) cyc(1'b0, 5'd0, 1'b0);
    obs = {bus.fifo_pull, bus.mux_sel, bus.acc_clear, bus.acc_valid,
           bus.round_en, bus.push_out, bus.coef_ready, bus.busy};
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want %b", obs, 9'd0);
    end
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.fifo_pull !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b pull=%b want 0 0", bus.busy, bus.fifo_pull);
    end
  endtask

  // Writes 0..13 and out-of-range 20, then 14; expects ready next cycle and a pull the cycle after.
  task automatic write_coefs_and_start(input string tag);
    int pushes;
    bit done;
    for (int a = 0; a <= 14; a++) begin
      cyc(1'b1, (a == 14) ? 5'd20 : 5'(a), 1'b0);
      checks++;
      if (bus.fifo_pull !== 1'b0 || bus.coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s_gated step %0d got pull=%b ready=%b want 0 0", tag, a, bus.fifo_pull, bus.coef_ready);
      end
    end
    cyc(1'b1, 5'd14, 1'b0);
    checks++;
    if (bus.coef_ready !== 1'b0 || bus.fifo_pull !== 1'b0) begin
      errors++;
      $display("FAIL %s_last_write got ready=%b pull=%b want 0 0", tag, bus.coef_ready, bus.fifo_pull);
    end
    cyc(1'b0, 5'd0, 1'b0);
    checks++;
    if (bus.coef_ready !== 1'b1 || bus.fifo_pull !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_next got ready=%b pull=%b want 1 0", tag, bus.coef_ready, bus.fifo_pull);
    end
    cyc(1'b0, 5'd0, 1'b0);
    checks++;
    if (bus.fifo_pull !== 1'b1) begin
      errors++;
      $display("FAIL %s_first_pull got %b want 1", tag, bus.fifo_pull);
    end
    pushes = 0;
    done   = 1'b0;
    for (int t = 0; t < 30 && !done; t++) begin
      cyc(1'b0, 5'd0, 1'b1);
      if (bus.push_out === 1'b1) pushes++;
      if (bus.busy === 1'b0) done = 1'b1;
    end
    checks++;
    if (!done || pushes != 1) begin
      errors++;
      $display("FAIL %s_drain got idle=%0d pushes=%0d want 1 1", tag, done, pushes);
    end
  endtask

  task automatic test_coef_gating();
    write_coefs_and_start("gate");
  endtask

  task automatic test_single();
    logic       e_pull, e_clr, e_av, e_rnd, e_push, e_busy;
    logic [1:0] e_mux;
    cyc(1'b0, 5'd0, 1'b0);
    for (int t = 0; t <= 8; t++) begin
      cyc(1'b0, 5'd0, (t == 0) ? 1'b0 : 1'b1);
      e_pull = (t == 0);
      e_mux  = (t >= 1 && t <= 3) ? 2'(t - 1) : 2'd2;
      e_clr  = (t == 3);
      e_av   = (t >= 3 && t <= 5);
      e_rnd  = (t == 6);
      e_push = (t == 7);
      e_busy = (t <= 7);
      checks++;
      if ({bus.fifo_pull, bus.mux_sel, bus.acc_clear, bus.acc_valid, bus.round_en, bus.push_out, bus.busy}
          !== {e_pull, e_mux, e_clr, e_av, e_rnd, e_push, e_busy}) begin
        errors++;
        $display("FAIL single t%0d got pull=%b mux=%0d clr=%b av=%b rnd=%b push=%b busy=%b want %b %0d %b %b %b %b %b",
                 t, bus.fifo_pull, bus.mux_sel, bus.acc_clear, bus.acc_valid, bus.round_en, bus.push_out,
                 bus.busy, e_pull, e_mux, e_clr, e_av, e_rnd, e_push, e_busy);
      end
    end
  endtask

  task automatic test_back_to_back();
    int   n_clr, n_av;
    logic e_pull, e_push;
    n_clr = 0;
    n_av  = 0;
    cyc(1'b0, 5'd0, 1'b0);
    for (int t = 0; t <= 26; t++) begin
      cyc(1'b0, 5'd0, (t <= 16) ? 1'b0 : 1'b1);
      e_pull = (t % 4 == 0) && (t <= 16);
      e_push = (t >= 7) && (t <= 23) && ((t - 7) % 4 == 0);
      if (bus.acc_clear === 1'b1) n_clr++;
      if (bus.acc_valid === 1'b1) n_av++;
      checks++;
      if (bus.fifo_pull !== e_pull || bus.push_out !== e_push) begin
        errors++;
        $display("FAIL stream t%0d got pull=%b push=%b want %b %b", t, bus.fifo_pull, bus.push_out, e_pull, e_push);
      end
      if (t == 24) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL stream_busy_end got %b want 0", bus.busy);
        end
      end
    end
    checks++;
    if (n_clr != 5 || n_av != 15) begin
      errors++;
      $display("FAIL stream_counts got clr=%0d av=%0d want 5 15", n_clr, n_av);
    end
  endtask

  task automatic test_starvation();
    logic e_pull, e_push;
    cyc(1'b0, 5'd0, 1'b0);
    for (int t = 0; t <= 17; t++) begin
      cyc(1'b0, 5'd0, ((t >= 3 && t <= 5) || t >= 8) ? 1'b1 : 1'b0);
      e_pull = (t == 0) || (t == 7);
      e_push = (t == 7) || (t == 14);
      checks++;
      if (bus.fifo_pull !== e_pull || bus.push_out !== e_push) begin
        errors++;
        $display("FAIL starve t%0d got pull=%b push=%b want %b %b", t, bus.fifo_pull, bus.push_out, e_pull, e_push);
      end
      if (t == 5 || t == 15) begin
        checks++;
        if (bus.busy !== (t == 5)) begin
          errors++;
          $display("FAIL starve_busy t%0d got %b want %b", t, bus.busy, (t == 5));
        end
      end
    end
  endtask

  task automatic test_coef_write_stream();
    logic e_pull, e_push;
    cyc(1'b0, 5'd0, 1'b0);
    for (int t = 0; t <= 15; t++) begin
      cyc((t == 4), 5'd3, (t >= 6) ? 1'b1 : 1'b0);
      e_pull = (t == 0) || (t == 5);
      e_push = (t == 7) || (t == 12);
      checks++;
      if (bus.fifo_pull !== e_pull || bus.push_out !== e_push || bus.coef_ready !== 1'b1) begin
        errors++;
        $display("FAIL coefwr t%0d got pull=%b push=%b ready=%b want %b %b 1",
                 t, bus.fifo_pull, bus.push_out, bus.coef_ready, e_pull, e_push);
      end
      if (t == 13) begin
        checks++;
        if (bus.busy !== 1'b0) begin
          errors++;
          $display("FAIL coefwr_busy_end got %b want 0", bus.busy);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [8:0] obs;
    cyc(1'b0, 5'd0, 1'b0);
    for (int t = 0; t <= 3; t++) cyc(1'b0, 5'd0, (t == 0) ? 1'b0 : 1'b1);
    @(posedge clk);
    #1;
    Reset          = 1'b1;
    bus.fifo_empty = 1'b0;
    @(negedge clk);
    obs = {bus.fifo_pull, bus.mux_sel, bus.acc_clear, bus.acc_valid,
           bus.round_en, bus.push_out, bus.coef_ready, bus.busy};
    checks++;
    if (obs !== 9'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want %b", obs, 9'd0);
    end
    @(posedge clk);
    #1;
    Reset = 1'b0;
    @(negedge clk);
    for (int t = 6; t <= 12; t++) begin
      cyc(1'b0, 5'd0, 1'b0);
      checks++;
      if (bus.push_out !== 1'b0 || bus.fifo_pull !== 1'b0 || bus.coef_ready !== 1'b0) begin
        errors++;
        $display("FAIL midreset_quiet t%0d got push=%b pull=%b ready=%b want 0 0 0",
                 t, bus.push_out, bus.fifo_pull, bus.coef_ready);
      end
    end
    write_coefs_and_start("rearm");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_coef_gating();
    test_single();
    test_back_to_back();
    test_starvation();
    test_coef_write_stream();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
